// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter: state encoding and default sizing.
package fifo_write_arbiter_pkg;

    typedef enum logic {
        kStateIdle = 1'b0,
        kStateLock = 1'b1
    } state_t;

    localparam int kDefaultWidth  = 32;
    localparam int kDefaultReqNum = 4;

endpackage

// File: rtl/fifo_write_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set bit of req_vec scanning from ptr upward, wrapping.
module rr_priority_picker #(
    parameter int kReqNum  = 4,
    parameter int kIdWidth = 2
) (
    input  logic [kReqNum-1:0]  req_vec,
    input  logic [kIdWidth-1:0] ptr,
    output logic                found,
    output logic [kIdWidth-1:0] idx
);

    always_comb begin
        int unsigned pos;
        logic [kIdWidth-1:0] pos_idx;
        pos     = 0;
        pos_idx = '0;
        found   = 1'b0;
        idx     = ptr;
        for (int unsigned k = 0; k < kReqNum; k++) begin
            // explicit wrap so non-power-of-two kReqNum never aliases by overflow
            pos = 32'(ptr) + k;
            if (pos >= kReqNum) begin
                pos = pos - kReqNum;
            end
            pos_idx = kIdWidth'(pos);
            if (!found && req_vec[pos_idx]) begin
                found = 1'b1;
                idx   = pos_idx;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter in front of one shared FIFO; packets are not interleaved and reads win the cycle.
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int kReqNum  = kDefaultReqNum,
    parameter int kWidth   = kDefaultWidth,
    parameter int kIdWidth = $clog2(kReqNum)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [kReqNum-1:0]         req_valid,
    input  logic [kReqNum-1:0]         req_last,
    input  logic [kReqNum*kWidth-1:0]  req_data,
    output logic [kReqNum-1:0]         req_ready,
    input  logic                       read_req,
    output logic                       read_ack,
    output logic [kWidth-1:0]          read_data,
    output logic                       fifo_write_en,
    output logic [kWidth-1:0]          fifo_write_data,
    output logic                       fifo_read_en,
    input  logic [kWidth-1:0]          fifo_read_data,
    input  logic                       fifo_is_full,
    input  logic                       fifo_is_empty,
    output logic [kIdWidth-1:0]        grant_id,
    output logic                       busy
);

    state_t                state;
    logic [kIdWidth-1:0]   rr_ptr;
    logic [kIdWidth-1:0]   owner;
    logic                  cand_found;
    logic [kIdWidth-1:0]   cand;
    logic [kIdWidth-1:0]   sel;
    logic                  rd_go;
    logic                  wr_allow;
    logic [kWidth-1:0]     data_arr [kReqNum];

    function automatic logic [kIdWidth-1:0] wrap_inc(input logic [kIdWidth-1:0] v);
        return (32'(v) == kReqNum - 1) ? '0 : v + kIdWidth'(1);
    endfunction

    rr_priority_picker #(
        .kReqNum (kReqNum),
        .kIdWidth(kIdWidth)
    ) u_picker (
        .req_vec(req_valid),
        .ptr    (rr_ptr),
        .found  (cand_found),
        .idx    (cand)
    );

    always_comb begin
        for (int unsigned i = 0; i < kReqNum; i++) begin
            data_arr[i] = req_data[i*kWidth +: kWidth];
        end
    end

    // A read against an empty FIFO is not performed, so it must not steal the write slot.
    assign rd_go        = !rst && read_req && !fifo_is_empty;
    assign wr_allow     = !fifo_is_full && !rd_go;
    assign fifo_read_en = rd_go;
    assign read_ack     = rd_go;
    assign read_data    = fifo_read_data;

    assign sel = (state == kStateLock) ? owner : cand;

    always_comb begin
        req_ready = '0;
        if (!rst && wr_allow) begin
            if (state == kStateLock) begin
                req_ready[owner] = req_valid[owner];
            end else if (cand_found) begin
                req_ready[cand] = 1'b1;
            end
        end
    end

    assign fifo_write_en   = |req_ready;
    assign fifo_write_data = data_arr[sel];
    assign grant_id        = rst ? '0 : sel;
    assign busy            = !rst && (state == kStateLock);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= kStateIdle;
            rr_ptr <= '0;
            owner  <= '0;
        end else if (fifo_write_en) begin
            if (req_last[sel]) begin
                state  <= kStateIdle;
                rr_ptr <= wrap_inc(sel);
            end else begin
                state <= kStateLock;
                owner <= sel;
            end
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with a depth-16 show-ahead FIFO model on its write/read ports.
module tb_fifo_write_arbiter;

    localparam int kReqNum  = 4;
    localparam int kWidth   = 32;
    localparam int kIdWidth = 2;

    logic                      clk;
    logic                      rst;
    logic [kReqNum-1:0]        req_valid;
    logic [kReqNum-1:0]        req_last;
    logic [kReqNum*kWidth-1:0] req_data;
    logic [kReqNum-1:0]        req_ready;
    logic                      read_req;
    logic                      read_ack;
    logic [kWidth-1:0]         read_data;
    logic                      fifo_write_en;
    logic [kWidth-1:0]         fifo_write_data;
    logic                      fifo_read_en;
    logic [kWidth-1:0]         fifo_read_data;
    logic                      fifo_is_full;
    logic                      fifo_is_empty;
    logic [kIdWidth-1:0]       grant_id;
    logic                      busy;

    int errors = 0;
    int checks = 0;

    fifo_write_arbiter #(
        .kReqNum (kReqNum),
        .kWidth  (kWidth),
        .kIdWidth(kIdWidth)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_last       (req_last),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .read_req       (read_req),
        .read_ack       (read_ack),
        .read_data      (read_data),
        .fifo_write_en  (fifo_write_en),
        .fifo_write_data(fifo_write_data),
        .fifo_read_en   (fifo_read_en),
        .fifo_read_data (fifo_read_data),
        .fifo_is_full   (fifo_is_full),
        .fifo_is_empty  (fifo_is_empty),
        .grant_id       (grant_id),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: ignores read_en when write_en is high, like the real FIFO.
    logic [kWidth-1:0] fmem [16];
    logic [3:0]        fwr, frd;
    logic [4:0]        fcnt;
    logic              fw, fr;

    assign fw             = fifo_write_en && (fcnt != 5'd16);
    assign fr             = fifo_read_en && !fifo_write_en && (fcnt != 5'd0);
    assign fifo_is_full   = (fcnt == 5'd16);
    assign fifo_is_empty  = (fcnt == 5'd0);
    assign fifo_read_data = fmem[frd];

    always @(posedge clk) begin
        if (rst) begin
            fwr  <= '0;
            frd  <= '0;
            fcnt <= '0;
        end else begin
            if (fw) begin
                fmem[fwr] <= fifo_write_data;
                fwr       <= fwr + 4'd1;
            end
            if (fr) frd <= frd + 4'd1;
            fcnt <= fcnt + (fw ? 5'd1 : 5'd0) - (fr ? 5'd1 : 5'd0);
        end
    end

    task automatic idle_inputs();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        read_req  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst       = 1'b1;
        read_req  = 1'b0;
        req_valid = '1;
        req_last  = '1;
        for (int i = 0; i < kReqNum; i++) req_data[i*kWidth +: kWidth] = 32'hA000_0000 + i;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000 || fifo_write_en !== 1'b0 || read_ack !== 1'b0) begin
                errors++;
                $display("FAIL reset_gate c%0d: ready=%b wen=%b ack=%b want 0000/0/0", c, req_ready, fifo_write_en, read_ack);
            end
            checks++;
            if (busy !== 1'b0 || grant_id !== 2'd0) begin
                errors++;
                $display("FAIL reset_status c%0d: busy=%b grant=%0d want 0/0", c, busy, grant_id);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001 || fifo_write_en !== 1'b1 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_first_grant: ready=%b wen=%b grant=%0d want 0001/1/0", req_ready, fifo_write_en, grant_id);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_fairness();
        int exp_g [6] = '{0, 1, 2, 3, 0, 1};
        logic [kReqNum-1:0] exp_r;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req_valid = '1;
            req_last  = '1;
            for (int i = 0; i < kReqNum; i++) req_data[i*kWidth +: kWidth] = 32'h2000_0000 + i;
            #1;
            exp_r = 4'b0001 << exp_g[c];
            checks++;
            if (req_ready !== exp_r || grant_id !== 2'(exp_g[c]) ||
                fifo_write_data !== 32'h2000_0000 + exp_g[c]) begin
                errors++;
                $display("FAIL fairness c%0d: ready=%b grant=%0d data=%h want %b/%0d/%h",
                         c, req_ready, grant_id, fifo_write_data, exp_r, exp_g[c], 32'h2000_0000 + exp_g[c]);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_packet_lock();
        logic [3:0]  exp_r [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
        logic        exp_b [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] exp_d [4] = '{32'h0000_1100, 32'h0000_1101, 32'h0000_1102, 32'h0000_2222};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req_valid = {1'b0, 1'b1, (c < 3), 1'b0};
            req_last  = {1'b0, 1'b1, (c == 2), 1'b0};
            req_data[1*kWidth +: kWidth] = 32'h0000_1100 + c;
            req_data[2*kWidth +: kWidth] = 32'h0000_2222;
            #1;
            checks++;
            if (req_ready !== exp_r[c] || busy !== exp_b[c] || fifo_write_data !== exp_d[c]) begin
                errors++;
                $display("FAIL packet_lock c%0d: ready=%b busy=%b data=%h want %b/%b/%h",
                         c, req_ready, busy, fifo_write_data, exp_r[c], exp_b[c], exp_d[c]);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_full_backpressure();
        do_reset();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            req_valid = 4'b0001;
            req_last  = 4'b0001;
            req_data[0 +: kWidth] = 32'hD000_0000 + k;
            #1;
            checks++;
            if (req_ready !== 4'b0001) begin
                errors++;
                $display("FAIL full_fill k%0d: ready=%b want 0001", k, req_ready);
            end
        end
        @(negedge clk);
        req_data[0 +: kWidth] = 32'hD000_0010;
        #1;
        checks++;
        if (req_ready !== 4'b0000 || fifo_write_en !== 1'b0 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL full_stall: ready=%b wen=%b grant=%0d want 0000/0/0", req_ready, fifo_write_en, grant_id);
        end
        @(negedge clk);
        read_req = 1'b1;
        #1;
        checks++;
        if (read_ack !== 1'b1 || fifo_read_en !== 1'b1 || fifo_write_en !== 1'b0 ||
            req_ready !== 4'b0000 || read_data !== 32'hD000_0000) begin
            errors++;
            $display("FAIL full_read: ack=%b ren=%b wen=%b ready=%b rdata=%h want 1/1/0/0000/d0000000",
                     read_ack, fifo_read_en, fifo_write_en, req_ready, read_data);
        end
        @(negedge clk);
        read_req = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001 || fifo_write_en !== 1'b1 || fifo_write_data !== 32'hD000_0010) begin
            errors++;
            $display("FAIL full_resume: ready=%b wen=%b data=%h want 0001/1/d0000010",
                     req_ready, fifo_write_en, fifo_write_data);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_read_priority();
        logic       exp_a [3] = '{1'b1, 1'b1, 1'b0};
        logic [3:0] exp_r [3] = '{4'b0000, 4'b0000, 4'b1000};
        do_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            req_valid = 4'b0001;
            req_last  = 4'b0001;
            req_data[0 +: kWidth] = 32'h5000_0000 + k;
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            read_req  = 1'b1;
            req_valid = 4'b1000;
            req_last  = 4'b1000;
            req_data[3*kWidth +: kWidth] = 32'h3333_0000;
            #1;
            checks++;
            if (read_ack !== exp_a[c] || req_ready !== exp_r[c] || fifo_write_en !== exp_r[c][3]) begin
                errors++;
                $display("FAIL read_priority c%0d: ack=%b ready=%b wen=%b want %b/%b/%b",
                         c, read_ack, req_ready, fifo_write_en, exp_a[c], exp_r[c], exp_r[c][3]);
            end
            if (c < 2) begin
                checks++;
                if (read_data !== 32'h5000_0000 + c) begin
                    errors++;
                    $display("FAIL read_data c%0d: got %h want %h", c, read_data, 32'h5000_0000 + c);
                end
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_owner_stall();
        do_reset();
        @(negedge clk);
        req_valid = 4'b0100;
        req_last  = 4'b0000;
        req_data[2*kWidth +: kWidth] = 32'h0000_0202;
        #1;
        checks++;
        if (req_ready !== 4'b0100 || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL stall_first: ready=%b grant=%0d want 0100/2", req_ready, grant_id);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid = 4'b1011;
            req_last  = 4'b1011;
            #1;
            checks++;
            if (req_ready !== 4'b0000 || fifo_write_en !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd2) begin
                errors++;
                $display("FAIL stall_hold c%0d: ready=%b wen=%b busy=%b grant=%0d want 0000/0/1/2",
                         c, req_ready, fifo_write_en, busy, grant_id);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL stall_rst: ready=%b busy=%b grant=%0d want 0000/0/0", req_ready, busy, grant_id);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001 || busy !== 1'b0 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL stall_after_rst: ready=%b busy=%b grant=%0d want 0001/0/0", req_ready, busy, grant_id);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_fairness();
        test_packet_lock();
        test_full_backpressure();
        test_read_priority();
        test_owner_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
